// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - pipelined immediate sign/zero extender with shift and elastic buffer
module imm_ext_pipe #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 32,
  parameter int W0    = 16,
  parameter int W1    = 21,
  parameter int W2    = 26
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [IN_W-1:0]  UNEXT,
  input  logic [1:0]       MODE,
  input  logic             SIGNED,
  input  logic [1:0]       SHL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [OUT_W-1:0] EXT,
  output logic             LOSS
);

  logic [OUT_W-1:0] x;
  logic [OUT_W-1:0] r;
  logic             loss_c;

  logic             o_valid;
  logic [OUT_W-1:0] o_ext;
  logic             o_loss;
  logic             s_valid;
  logic [OUT_W-1:0] s_ext;
  logic             s_loss;

  logic             accept;
  logic             emit;

  // Select the field width, extend to OUT_W, shift, and detect discarded significant bits
  always_comb begin
    x = '0;
    case (MODE)
      2'b00:   x = {{(OUT_W-W0){SIGNED & UNEXT[W0-1]}}, UNEXT[W0-1:0]};
      2'b01:   x = {{(OUT_W-W1){SIGNED & UNEXT[W1-1]}}, UNEXT[W1-1:0]};
      2'b10:   x = {{(OUT_W-W2){SIGNED & UNEXT[W2-1]}}, UNEXT[W2-1:0]};
      default: x = {{(OUT_W-IN_W){SIGNED & UNEXT[IN_W-1]}}, UNEXT};
    endcase
    r = x << SHL;
    // Each bit shifted out must equal the new sign bit (signed) or be zero (unsigned)
    loss_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i < int'(SHL)) begin
        if (SIGNED) begin
          if (x[OUT_W-1-i] != r[OUT_W-1]) loss_c = 1'b1;
        end else begin
          if (x[OUT_W-1-i]) loss_c = 1'b1;
        end
      end
    end
  end

  // Skid occupancy alone gates input, so IN_READY never depends on OUT_READY
  assign IN_READY  = ~s_valid;
  assign accept    = IN_VALID & ~s_valid;
  assign emit      = o_valid & OUT_READY;
  assign OUT_VALID = o_valid;
  assign EXT       = o_ext;
  assign LOSS      = o_loss;

  // Two-entry elastic buffer: O feeds the output, S catches the one beat in flight during a stall
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_valid <= 1'b0;
      o_ext   <= '0;
      o_loss  <= 1'b0;
      s_valid <= 1'b0;
      s_ext   <= '0;
      s_loss  <= 1'b0;
    end else begin
      if (emit) begin
        if (s_valid) begin
          o_ext   <= s_ext;
          o_loss  <= s_loss;
          s_valid <= 1'b0;
        end else if (accept) begin
          o_ext   <= r;
          o_loss  <= loss_c;
        end else begin
          o_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!o_valid) begin
          o_valid <= 1'b1;
          o_ext   <= r;
          o_loss  <= loss_c;
        end else begin
          s_valid <= 1'b1;
          s_ext   <= r;
          s_loss  <= loss_c;
        end
      end
    end
  end

endmodule
